mipi_rx_lane_ctrl: RTL and testbench

Per-lane sequencer for the MIPI CSI-2 receive byte path. Sits between the LP/HS lane detector and the byte aligner on one side and the packet/pixel unpacker on the other. Controls the aligner's reset so it re-hunts for the 0xB8 sync byte on every HS burst, and parses the 4-byte packet header. Frames the payload with start/end strobes, then forces the aligner back into reset once the packet's last CRC byte has been consumed.

---
 rtl/mipi_rx_pkg.sv | 24 ++
 rtl/mipi_rx_lane_ctrl_if.sv | 30 +++
 rtl/mipi_rx_hdr_capture.sv | 43 ++++
 rtl/mipi_rx_lane_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mipi_rx_lane_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mipi_rx_pkg.sv
// Shared types and constants for the MIPI CSI-2 receive lane controller.
package mipi_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_SYNC,
    ST_HEADER,
    ST_PAYLOAD,
    ST_CRC,
    ST_DONE
  } state_t;

  localparam logic [7:0]  SYNC_BYTE      = 8'hB8;
  localparam int unsigned HDR_BYTES      = 4;
  localparam int unsigned CRC_BYTES      = 2;
  localparam logic [5:0]  SHORT_ID_LIMIT = 6'h0F;

  // Data types at or below the limit carry no payload and no CRC.
  function automatic logic is_short(input logic [7:0] data_id, input logic [5:0] limit);
    return (data_id[5:0] <= limit);
  endfunction

endpackage

// File: rtl/mipi_rx_lane_ctrl_if.sv
// Byte-path bundle between lane detector/aligner and the lane controller.
interface mipi_rx_lane_ctrl_if;

  logic        lp_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        aligner_rst_o;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        pkt_start_o;
  logic        pkt_end_o;
  logic [7:0]  data_id_o;
  logic [15:0] word_count_o;
  logic        abort_o;
  logic        timeout_err_o;
  logic        sync_err_o;

  modport master (
    output lp_i, byte_i, byte_valid_i,
    input  aligner_rst_o, data_o, data_valid_o, pkt_start_o, pkt_end_o,
           data_id_o, word_count_o, abort_o, timeout_err_o, sync_err_o
  );

  modport slave (
    input  lp_i, byte_i, byte_valid_i,
    output aligner_rst_o, data_o, data_valid_o, pkt_start_o, pkt_end_o,
           data_id_o, word_count_o, abort_o, timeout_err_o, sync_err_o
  );

endinterface

// File: rtl/mipi_rx_hdr_capture.sv
// Four-byte packet header capture: DataID, WC low, WC high, ECC (discarded).
// done is a combinational strobe on the ECC byte; fields are registered.
module mipi_rx_hdr_capture
  import mipi_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [7:0]  data_id,
  output logic [15:0] word_count,
  output logic        done
);

  logic [1:0] cnt;
  logic [7:0] b0, b1, b2;

  // Byte counter and field registers; clr re-arms for the next header.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
      b0  <= '0;
      b1  <= '0;
      b2  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      case (cnt)
        2'd0:    b0 <= data;
        2'd1:    b1 <= data;
        2'd2:    b2 <= data;
        default: ;
      endcase
      cnt <= (cnt == 2'(HDR_BYTES - 1)) ? '0 : cnt + 2'd1;
    end
  end

  assign done       = en && !clr && (cnt == 2'(HDR_BYTES - 1));
  assign data_id    = b0;
  assign word_count = {b2, b1};

endmodule

// File: rtl/mipi_rx_lane_ctrl.sv
// Per-lane CSI-2 receive sequencer: aligner reset control, header parse,
// payload framing and abort handling. All outputs are registered.
// Optional HUNT watchdog: define MIPI_RX_LANE_CTRL_TIMEOUT_EN.
module mipi_rx_lane_ctrl
  import mipi_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [5:0]  SHORT_ID_MAX   = SHORT_ID_LIMIT
) (
  input logic                clk_i,
  input logic                reset_i,
  mipi_rx_lane_ctrl_if.slave bus
);

  state_t      state, state_n;
  logic [15:0] rem, rem_n;
  logic        crc_cnt, crc_n;
  logic        align_q, align_n;
  logic [7:0]  data_q, data_n;
  logic        dv_q, dv_n;
  logic        start_q, start_n;
  logic        end_q, end_n;
  logic        abort_q, abort_n;
  logic        serr_q, serr_n;
  logic        terr_q, terr_n;
  logic [7:0]  id_q, id_n;
  logic [15:0] wc_q, wc_n;

  logic        hdr_en, hdr_clr, hdr_done;
  logic [7:0]  hdr_id;
  logic [15:0] hdr_wc;
  logic        active, framed, streaming, last_crc;

`ifdef MIPI_RX_LANE_CTRL_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tcnt, tcnt_n;
`endif

  assign hdr_en  = bus.byte_valid_i && !bus.lp_i && (state == ST_SYNC || state == ST_HEADER);
  assign hdr_clr = !(state == ST_SYNC || state == ST_HEADER);

  mipi_rx_hdr_capture u_hdr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr        (hdr_clr),
    .en         (hdr_en),
    .data       (bus.byte_i),
    .data_id    (hdr_id),
    .word_count (hdr_wc),
    .done       (hdr_done)
  );

  assign active    = (state inside {ST_HUNT, ST_SYNC, ST_HEADER, ST_PAYLOAD, ST_CRC});
  assign streaming = (state inside {ST_SYNC, ST_HEADER, ST_PAYLOAD, ST_CRC});
  assign framed    = (state inside {ST_HEADER, ST_PAYLOAD, ST_CRC});
  assign last_crc  = (state == ST_CRC) && crc_cnt && bus.byte_valid_i;

  // Next-state and next-output logic.
  // The sync byte is checked on the edge that leaves HUNT, so SYNC is the
  // cycle after a good 0xB8 and already carries header byte 0.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    crc_n   = crc_cnt;
    data_n  = data_q;
    dv_n    = 1'b0;
    start_n = 1'b0;
    end_n   = 1'b0;
    abort_n = 1'b0;
    serr_n  = 1'b0;
    terr_n  = terr_q;
    id_n    = id_q;
    wc_n    = wc_q;

    if (last_crc) begin
      end_n   = 1'b1;
      state_n = ST_DONE;
    end else if (active && (bus.lp_i || (streaming && !bus.byte_valid_i))) begin
      abort_n = framed;
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!bus.lp_i) state_n = ST_HUNT;
        ST_HUNT: begin
          if (bus.byte_valid_i) begin
            if (bus.byte_i == SYNC_BYTE) begin
              state_n = ST_SYNC;
            end else begin
              serr_n  = 1'b1;
              state_n = ST_DONE;
            end
          end
`ifdef MIPI_RX_LANE_CTRL_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            terr_n  = 1'b1;
            state_n = ST_DONE;
          end
`endif
        end
        ST_SYNC: state_n = ST_HEADER;
        ST_HEADER: begin
          if (hdr_done) begin
            start_n = 1'b1;
            id_n    = hdr_id;
            wc_n    = hdr_wc;
            if (is_short(hdr_id, SHORT_ID_MAX)) begin
              end_n   = 1'b1;
              state_n = ST_DONE;
            end else if (hdr_wc == '0) begin
              state_n = ST_CRC;
            end else begin
              rem_n   = hdr_wc;
              state_n = ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          data_n = bus.byte_i;
          dv_n   = 1'b1;
          if (rem != '0) rem_n = rem - 16'd1;
          if (rem <= 16'd1) state_n = ST_CRC;
        end
        ST_CRC:  crc_n = 1'b1;
        ST_DONE: if (bus.lp_i) state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end

    if (state_n != ST_CRC) crc_n = 1'b0;
    align_n = (state_n == ST_IDLE) || (state_n == ST_DONE);

`ifdef MIPI_RX_LANE_CTRL_TIMEOUT_EN
    tcnt_n = (state == ST_HUNT && state_n == ST_HUNT) ? tcnt + TW'(1) : '0;
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      rem     <= '0;
      crc_cnt <= 1'b0;
      align_q <= 1'b1;
      data_q  <= '0;
      dv_q    <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      abort_q <= 1'b0;
      serr_q  <= 1'b0;
      terr_q  <= 1'b0;
      id_q    <= '0;
      wc_q    <= '0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      crc_cnt <= crc_n;
      align_q <= align_n;
      data_q  <= data_n;
      dv_q    <= dv_n;
      start_q <= start_n;
      end_q   <= end_n;
      abort_q <= abort_n;
      serr_q  <= serr_n;
      terr_q  <= terr_n;
      id_q    <= id_n;
      wc_q    <= wc_n;
    end
  end

`ifdef MIPI_RX_LANE_CTRL_TIMEOUT_EN
  // HUNT watchdog counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) tcnt <= '0;
    else         tcnt <= tcnt_n;
  end
`endif

  assign bus.aligner_rst_o = align_q;
  assign bus.data_o        = data_q;
  assign bus.data_valid_o  = dv_q;
  assign bus.pkt_start_o   = start_q;
  assign bus.pkt_end_o     = end_q;
  assign bus.abort_o       = abort_q;
  assign bus.sync_err_o    = serr_q;
  assign bus.timeout_err_o = terr_q;
  assign bus.data_id_o     = id_q;
  assign bus.word_count_o  = wc_q;

endmodule

// File: tb/tb_mipi_rx_lane_ctrl.sv
// Directed self-checking bench for mipi_rx_lane_ctrl.
module tb_mipi_rx_lane_ctrl;
  import mipi_rx_pkg::*;

  logic clk = 1'b0;
  logic reset_i;
  int   compared = 0;
  int   mismatched = 0;

  int          n_start, n_end, n_dv, n_abort;
  logic [7:0]  got[$];

  mipi_rx_lane_ctrl_if bus();

  mipi_rx_lane_ctrl #(.TIMEOUT_CYCLES(64), .SHORT_ID_MAX(6'h0F)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clr_obs();
    n_start = 0; n_end = 0; n_dv = 0; n_abort = 0;
    got.delete();
  endtask

  // Drive one byte-clock of inputs, then observe registered outputs.
  task automatic cyc(input logic lp, input logic v, input logic [7:0] b);
    bus.lp_i = lp; bus.byte_valid_i = v; bus.byte_i = b;
    @(posedge clk); #1;
    if (bus.pkt_start_o)  n_start++;
    if (bus.pkt_end_o)    n_end++;
    if (bus.abort_o)      n_abort++;
    if (bus.data_valid_o) begin n_dv++; got.push_back(bus.data_o); end
  endtask

  task automatic to_idle();
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    clr_obs();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    bus.lp_i = 1'b1; bus.byte_valid_i = 1'b0; bus.byte_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (bus.aligner_rst_o !== 1'b1) begin mismatched++; $display("FAIL reset_aligner_rst: got %b want 1", bus.aligner_rst_o); end
    compared++; if ({bus.data_valid_o, bus.pkt_start_o, bus.pkt_end_o, bus.abort_o, bus.timeout_err_o, bus.sync_err_o} !== 6'b0) begin
      mismatched++; $display("FAIL reset_strobes: got %b want 000000", {bus.data_valid_o, bus.pkt_start_o, bus.pkt_end_o, bus.abort_o, bus.timeout_err_o, bus.sync_err_o}); end
    compared++; if ({bus.data_o, bus.data_id_o, bus.word_count_o} !== 32'h0) begin
      mismatched++; $display("FAIL reset_fields: got %h want 00000000", {bus.data_o, bus.data_id_o, bus.word_count_o}); end
    #2 reset_i = 1'b0;
    to_idle();
  endtask

  task automatic test_long();
    logic [7:0] seq [11] = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'hEE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC0, 8'hC1};
    logic [31:0] packed_data;
    to_idle();
    cyc(1'b0, 1'b0, 8'h00);
    compared++; if (bus.aligner_rst_o !== 1'b0) begin mismatched++; $display("FAIL long_hunt_rst: got %b want 0", bus.aligner_rst_o); end
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, 1'b1, seq[i]);
      if (i == 4) begin
        compared++; if (bus.pkt_start_o !== 1'b1) begin mismatched++; $display("FAIL long_start: got %b want 1", bus.pkt_start_o); end
        compared++; if (bus.data_id_o !== 8'h2A) begin mismatched++; $display("FAIL long_id: got %h want 2a", bus.data_id_o); end
        compared++; if (bus.word_count_o !== 16'h0004) begin mismatched++; $display("FAIL long_wc: got %h want 0004", bus.word_count_o); end
        compared++; if (bus.data_valid_o !== 1'b0) begin mismatched++; $display("FAIL long_dv_at_start: got %b want 0", bus.data_valid_o); end
      end
      if (i == 5) begin
        compared++; if ({bus.data_valid_o, bus.data_o} !== 9'h111) begin mismatched++; $display("FAIL long_first_byte: got %h want 111", {bus.data_valid_o, bus.data_o}); end
      end
      if (i == 9) begin
        compared++; if (bus.pkt_end_o !== 1'b0) begin mismatched++; $display("FAIL long_early_end: got %b want 0", bus.pkt_end_o); end
      end
      if (i == 10) begin
        compared++; if (bus.pkt_end_o !== 1'b1) begin mismatched++; $display("FAIL long_end: got %b want 1", bus.pkt_end_o); end
        compared++; if (bus.aligner_rst_o !== 1'b1) begin mismatched++; $display("FAIL long_done_rst: got %b want 1", bus.aligner_rst_o); end
      end
    end
    cyc(1'b0, 1'b1, 8'h55);
    compared++; if (bus.data_valid_o !== 1'b0) begin mismatched++; $display("FAIL long_stray: got %b want 0", bus.data_valid_o); end
    packed_data = (got.size() == 4) ? {got[0], got[1], got[2], got[3]} : 32'hFFFF_FFFF;
    compared++; if (packed_data !== 32'h11223344) begin mismatched++; $display("FAIL long_payload: got %h want 11223344 (n=%0d)", packed_data, got.size()); end
    compared++; if (n_start !== 1 || n_end !== 1) begin mismatched++; $display("FAIL long_pulse_counts: got start=%0d end=%0d want 1 1", n_start, n_end); end
    cyc(1'b1, 1'b0, 8'h00);
    compared++; if (bus.aligner_rst_o !== 1'b1) begin mismatched++; $display("FAIL long_idle_rst: got %b want 1", bus.aligner_rst_o); end
  endtask

  task automatic test_short();
    logic [7:0] seq [5] = '{8'hB8, 8'h00, 8'h01, 8'h00, 8'hEE};
    to_idle();
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, seq[i]);
    compared++; if ({bus.pkt_start_o, bus.pkt_end_o, bus.aligner_rst_o} !== 3'b111) begin
      mismatched++; $display("FAIL short_start_end_rst: got %b want 111", {bus.pkt_start_o, bus.pkt_end_o, bus.aligner_rst_o}); end
    compared++; if ({bus.data_id_o, bus.word_count_o} !== 24'h000001) begin
      mismatched++; $display("FAIL short_fields: got %h want 000001", {bus.data_id_o, bus.word_count_o}); end
    cyc(1'b0, 1'b1, 8'h77);
    compared++; if (n_dv !== 0 || n_start !== 1) begin mismatched++; $display("FAIL short_counts: got dv=%0d start=%0d want 0 1", n_dv, n_start); end
  endtask

  task automatic test_wc0();
    logic [7:0] seq [7] = '{8'hB8, 8'h2B, 8'h00, 8'h00, 8'hEE, 8'hC0, 8'hC1};
    to_idle();
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, seq[i]);
      if (i == 4) begin
        compared++; if ({bus.pkt_start_o, bus.pkt_end_o} !== 2'b10) begin mismatched++; $display("FAIL wc0_start: got %b want 10", {bus.pkt_start_o, bus.pkt_end_o}); end
      end
      if (i == 6) begin
        compared++; if (bus.pkt_end_o !== 1'b1) begin mismatched++; $display("FAIL wc0_end: got %b want 1", bus.pkt_end_o); end
      end
    end
    compared++; if (n_dv !== 0) begin mismatched++; $display("FAIL wc0_no_data: got %0d want 0", n_dv); end
  endtask

  task automatic test_abort_lp();
    logic [7:0] seq [7] = '{8'hB8, 8'h2A, 8'h08, 8'h00, 8'hEE, 8'h11, 8'h22};
    to_idle();
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, seq[i]);
    cyc(1'b1, 1'b1, 8'h33);
    compared++; if ({bus.abort_o, bus.pkt_end_o, bus.aligner_rst_o} !== 3'b101) begin
      mismatched++; $display("FAIL abort_lp: got abort/end/rst=%b want 101", {bus.abort_o, bus.pkt_end_o, bus.aligner_rst_o}); end
    cyc(1'b1, 1'b0, 8'h00);
    compared++; if (bus.abort_o !== 1'b0) begin mismatched++; $display("FAIL abort_one_cycle: got %b want 0", bus.abort_o); end
    compared++; if (n_dv !== 2 || n_end !== 0) begin mismatched++; $display("FAIL abort_counts: got dv=%0d end=%0d want 2 0", n_dv, n_end); end
  endtask

  task automatic test_valid_drop();
    to_idle();
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hB8);
    cyc(1'b0, 1'b1, 8'h2A);
    cyc(1'b0, 1'b1, 8'h04);
    cyc(1'b0, 1'b0, 8'h00);
    compared++; if ({bus.abort_o, bus.aligner_rst_o} !== 2'b11) begin
      mismatched++; $display("FAIL valid_drop: got abort/rst=%b want 11", {bus.abort_o, bus.aligner_rst_o}); end
  endtask

  task automatic test_lp_on_last_crc();
    logic [7:0] seq [6] = '{8'hB8, 8'h2A, 8'h00, 8'h00, 8'hEE, 8'hC0};
    to_idle();
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, seq[i]);
    cyc(1'b1, 1'b1, 8'hC1);
    compared++; if ({bus.pkt_end_o, bus.abort_o, bus.aligner_rst_o} !== 3'b101) begin
      mismatched++; $display("FAIL lp_last_crc: got end/abort/rst=%b want 101", {bus.pkt_end_o, bus.abort_o, bus.aligner_rst_o}); end
  endtask

  task automatic test_sync_err();
    to_idle();
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h5C);
    compared++; if ({bus.sync_err_o, bus.aligner_rst_o} !== 2'b11) begin
      mismatched++; $display("FAIL sync_err: got err/rst=%b want 11", {bus.sync_err_o, bus.aligner_rst_o}); end
    cyc(1'b0, 1'b1, 8'hB8);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h2A);
    compared++; if (bus.sync_err_o !== 1'b0) begin mismatched++; $display("FAIL sync_err_pulse: got %b want 0", bus.sync_err_o); end
    compared++; if (n_start !== 0 || n_dv !== 0) begin mismatched++; $display("FAIL sync_err_done: got start=%0d dv=%0d want 0 0", n_start, n_dv); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seq [6] = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'hEE, 8'h11};
    to_idle();
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, seq[i]);
    #1 reset_i = 1'b1;
    #1;
    compared++; if ({bus.aligner_rst_o, bus.data_valid_o, bus.data_o, bus.data_id_o, bus.word_count_o} !== {2'b10, 32'h0}) begin
      mismatched++; $display("FAIL reset_mid: got %h want %h", {bus.aligner_rst_o, bus.data_valid_o, bus.data_o, bus.data_id_o, bus.word_count_o}, {2'b10, 32'h0}); end
    #1 reset_i = 1'b0;
    to_idle();
  endtask

  task automatic test_timeout();
    logic exp_terr;
`ifdef MIPI_RX_LANE_CTRL_TIMEOUT_EN
    exp_terr = 1'b1;
`else
    exp_terr = 1'b0;
`endif
    to_idle();
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 63; i++) cyc(1'b0, 1'b0, 8'h00);
    compared++; if ({bus.timeout_err_o, bus.aligner_rst_o} !== 2'b00) begin
      mismatched++; $display("FAIL timeout_early: got err/rst=%b want 00", {bus.timeout_err_o, bus.aligner_rst_o}); end
    cyc(1'b0, 1'b0, 8'h00);
    compared++; if ({bus.timeout_err_o, bus.aligner_rst_o} !== {exp_terr, exp_terr}) begin
      mismatched++; $display("FAIL timeout_fire: got err/rst=%b want %b", {bus.timeout_err_o, bus.aligner_rst_o}, {exp_terr, exp_terr}); end
    to_idle();
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'hB8);
    compared++; if (bus.timeout_err_o !== exp_terr) begin mismatched++; $display("FAIL timeout_sticky: got %b want %b", bus.timeout_err_o, exp_terr); end
    #1 reset_i = 1'b1;
    #1;
    compared++; if (bus.timeout_err_o !== 1'b0) begin mismatched++; $display("FAIL timeout_clear: got %b want 0", bus.timeout_err_o); end
    #1 reset_i = 1'b0;
  endtask

  initial begin
    clr_obs();
    test_reset();
    test_long();
    test_short();
    test_wc0();
    test_abort_lp();
    test_valid_drop();
    test_lp_on_last_crc();
    test_sync_err();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
